// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus master: data width, device
// selector codes (ReqAddr[15:12]) and the master FSM state type.
package bus_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    localparam logic [3:0] DEV_MEM = 4'h0;
    localparam logic [3:0] DEV_FP  = 4'h1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-cycle counter for the bus master. Counts consecutive Waitreq-high
// cycles of the current access and flags the cycle in which one more stall
// would exceed the TIMEOUT budget. TIMEOUT of 0 never expires.
module bus_timeout_ctr
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Restart on every new access, advance once per stalled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Expiry is only meaningful while a stall is actually being counted.
    assign expired = (TIMEOUT != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/mem_bus_master.sv
// Bus master between the pipeline MEM stage and the device bus. One access
// at a time: IDLE accepts a request and launches registered strobes, BUSY
// holds the bus steady until the device drops Waitreq or the wait budget
// runs out, then returns a one-cycle response pulse.
module mem_bus_master
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              ReqValid,
    input  logic              ReqWrite,
    input  logic [DATA_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqData,
    output logic              ReqReady,
    output logic              RspValid,
    output logic [DATA_W-1:0] RspData,
    output logic              RspError,
    output logic              Stall,
    output logic [DATA_W-1:0] DataAddr,
    output logic [DATA_W-1:0] BusIn,
    output logic              ReadData,
    output logic              WriteData,
    input  logic [DATA_W-1:0] BusOut,
    input  logic              Waitreq
);

    state_t state;
    logic   accept;
    logic   wait_cnt_en;
    logic   expired;

    assign ReqReady    = (state == IDLE);
    assign accept      = ReqValid & ReqReady;
    assign Stall       = (state == BUSY) | accept;
    assign wait_cnt_en = (state == BUSY) & Waitreq;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (Clock),
        .rst_n   (Resetn),
        .clear   (accept),
        .enable  (wait_cnt_en),
        .expired (expired)
    );

    // Master FSM with registered bus and response outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            DataAddr  <= '0;
            BusIn     <= '0;
            ReadData  <= 1'b0;
            WriteData <= 1'b0;
            RspValid  <= 1'b0;
            RspError  <= 1'b0;
            RspData   <= '0;
        end else begin
            RspValid <= 1'b0;
            RspError <= 1'b0;
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        DataAddr  <= ReqAddr;
                        BusIn     <= ReqData;
                        ReadData  <= ~ReqWrite;
                        WriteData <= ReqWrite;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (!Waitreq) begin
                        // Normal completion; stores leave RspData untouched.
                        ReadData  <= 1'b0;
                        WriteData <= 1'b0;
                        RspValid  <= 1'b1;
                        if (ReadData) begin
                            RspData <= BusOut;
                        end
                        state <= IDLE;
                    end else if (expired) begin
                        // Device held Waitreq too long: abort with an error.
                        ReadData  <= 1'b0;
                        WriteData <= 1'b0;
                        RspValid  <= 1'b1;
                        RspError  <= 1'b1;
                        RspData   <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
